// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding, data types and size helpers for the channel scheduler.
package cnn_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, NEXT, FIN} state_t;
    typedef logic [31:0] psum_t;
    function automatic int out_side(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction
    function automatic int cw_of(input int cmax);
        return $clog2(cmax + 1);
    endfunction
    localparam int O_DFLT  = out_side(10, 3, 1);
    localparam int OO_DFLT = O_DFLT * O_DFLT;
endpackage

// File: rtl/psum_buffer.sv
// psum_buffer: per-pixel accumulator with read-modify-write add and registered sum output.
module psum_buffer import cnn_pkg::*; #(
    parameter int DEPTH = 64,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          clear,
    input  logic [IW-1:0] idx,
    input  psum_t         addend,
    output psum_t         sum
);
    psum_t mem [DEPTH];
    psum_t sum_q, sum_d;
    always_comb sum_d = we ? (clear ? '0 : mem[idx]) + addend : sum_q;
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= sum_d;
        sum_q <= rst ? '0 : sum_d;
    end
    assign sum = sum_q;
endmodule

// File: rtl/conv_channel_scheduler.sv
// conv_channel_scheduler: walks the convolver over all (co, ci) passes and accumulates partial sums.
module conv_channel_scheduler import cnn_pkg::*; #(
    parameter int N = 10,
    parameter int K = 3,
    parameter int S = 1,
    parameter int CMAX = 16,
    parameter int AW = 16,
    parameter int DRAIN_MAX = 32,
    localparam int O = out_side(N, K, S),
    localparam int CW = cw_of(CMAX)
) (
    input  logic            clk,
    input  logic            global_rst,
    input  logic            start,
    input  logic [CW-1:0]   cin_cfg,
    input  logic [CW-1:0]   cout_cfg,
    output logic            act_rd_en,
    output logic [AW-1:0]   act_addr,
    input  logic [15:0]     act_data,
    output logic [2*CW-1:0] wt_sel,
    output logic            conv_rst,
    output logic            conv_ce,
    output logic [15:0]     conv_activation,
    input  logic [31:0]     conv_op,
    input  logic            valid_conv,
    input  logic            end_conv,
    output logic [31:0]     data_out,
    output logic            valid_op,
    output logic [CW-1:0]   out_ch,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int NN = N * N;
    localparam int OO = O * O;
    localparam int PW = $clog2(NN + 1);
    localparam int RW = $clog2(OO + 1);
    localparam int IW = $clog2(OO);
    localparam int DW = $clog2(DRAIN_MAX + 1);

    state_t state_q, state_d;
    logic [CW-1:0] cin_q, cin_d, cout_q, cout_d, ci_q, ci_d, co_q, co_d, out_ch_q, out_ch_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [RW-1:0] res_q, res_d;
    logic [DW-1:0] drn_q, drn_d;
    logic err_q, err_d, strm_q, strm_d, vo_q, vo_d;
    logic active, accept, last_ci, res_done;

    function automatic logic [CW-1:0] clamp_ch(input logic [CW-1:0] c);
        return c == '0 ? CW'(1) : (int'(c) > CMAX ? CW'(CMAX) : c);
    endfunction

    assign active   = state_q == STREAM || state_q == DRAIN;
    assign accept   = active && valid_conv && !end_conv && res_q != RW'(OO);
    assign last_ci  = ci_q == cin_q - 1'b1;
    assign res_done = res_q == RW'(OO) || (accept && res_q == RW'(OO - 1));

    always_comb begin
        state_d  = state_q;
        cin_d    = cin_q;
        cout_d   = cout_q;
        ci_d     = ci_q;
        co_d     = co_q;
        pix_d    = pix_q;
        res_d    = accept ? res_q + 1'b1 : res_q;
        drn_d    = drn_q;
        err_d    = err_q;
        strm_d   = state_q == STREAM;
        vo_d     = accept && last_ci;
        out_ch_d = vo_d ? co_q : out_ch_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                cin_d   = clamp_ch(cin_cfg);
                cout_d  = clamp_ch(cout_cfg);
                ci_d    = '0;
                co_d    = '0;
            end
            LOAD: begin
                state_d = STREAM;
                pix_d   = '0;
                res_d   = '0;
                drn_d   = '0;
            end
            STREAM: begin
                pix_d   = pix_q + 1'b1;
                state_d = pix_q == PW'(NN - 1) ? DRAIN : STREAM;
            end
            // A missing final result must not stall the layer: flag it and move on.
            DRAIN: begin
                drn_d   = drn_q + 1'b1;
                state_d = (res_done || drn_q == DW'(DRAIN_MAX - 1)) ? NEXT : DRAIN;
                err_d   = err_q || (!res_done && drn_q == DW'(DRAIN_MAX - 1));
            end
            NEXT: begin
                ci_d    = last_ci ? '0 : ci_q + 1'b1;
                co_d    = last_ci ? co_q + 1'b1 : co_q;
                state_d = (last_ci && co_q == cout_q - 1'b1) ? FIN : LOAD;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q  <= IDLE;
            cin_q    <= '0;
            cout_q   <= '0;
            ci_q     <= '0;
            co_q     <= '0;
            pix_q    <= '0;
            res_q    <= '0;
            drn_q    <= '0;
            err_q    <= 1'b0;
            strm_q   <= 1'b0;
            vo_q     <= 1'b0;
            out_ch_q <= '0;
        end else begin
            state_q  <= state_d;
            cin_q    <= cin_d;
            cout_q   <= cout_d;
            ci_q     <= ci_d;
            co_q     <= co_d;
            pix_q    <= pix_d;
            res_q    <= res_d;
            drn_q    <= drn_d;
            err_q    <= err_d;
            strm_q   <= strm_d;
            vo_q     <= vo_d;
            out_ch_q <= out_ch_d;
        end
    end

    psum_buffer #(.DEPTH(OO)) u_psum (
        .clk    (clk),
        .rst    (global_rst),
        .we     (accept),
        .clear  (ci_q == '0),
        .idx    (res_q[IW-1:0]),
        .addend (conv_op),
        .sum    (data_out)
    );

    assign act_rd_en       = state_q == STREAM;
    assign act_addr        = act_rd_en ? AW'(int'(ci_q) * NN + int'(pix_q)) : '0;
    assign wt_sel          = {co_q, ci_q};
    assign conv_rst        = state_q == LOAD;
    assign conv_ce         = strm_q || (state_q == DRAIN && res_q != RW'(OO));
    assign conv_activation = strm_q ? act_data : '0;
    assign valid_op        = vo_q;
    assign out_ch          = out_ch_q;
    assign busy            = state_q != IDLE;
    assign done            = state_q == FIN;
    assign err             = err_q;
endmodule

// File: doc/conv_channel_scheduler.md
Name: conv_channel_scheduler

Overview:
- Sequences the single-channel convolver across a runtime-configurable number of input and output channels.
- Per output channel: selects a weight set, streams each input channel's N×N activations into the convolver, and accumulates per-pixel partial sums across input channels.
- Emits finished 32-bit output pixels on the last input channel.
- Sits between the activation/weight memories and the convolver; its output stream feeds the relu/pooler stage.

Parameters:
- N, 10: input feature-map side.
- K, 3: kernel side.
- S, 1: stride.
- CMAX, 16: maximum channels per direction.
- AW, 16: activation address width.
- DRAIN_MAX, 32: maximum drain cycles per pass before timeout.
- O, localparam = (N-K)/S+1: output side, 8 by default.
- CW, localparam = $clog2(CMAX+1).

Ports:
- clk  in  1  clock.
- global_rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle layer start request.
- cin_cfg  in  CW  number of input channels; sampled at start.
- cout_cfg  in  CW  number of output channels; sampled at start.
- act_rd_en  out  1  activation memory read strobe.
- act_addr  out  AW  activation address = ci*N*N + pixel.
- act_data  in  16  read data, valid exactly 1 cycle after act_rd_en.
- wt_sel  out  2*CW  weight-bank select = {co, ci}; held stable for the whole pass.
- conv_rst  out  1  per-pass convolver reset.
- conv_ce  out  1  convolver clock enable.
- conv_activation  out  16  activation fed to the convolver.
- conv_op  in  32  convolver result.
- valid_conv  in  1  result valid.
- end_conv  in  1  convolver end marker.
- data_out  out  32  accumulated output pixel.
- valid_op  out  1  data_out valid, one-cycle pulse per pixel.
- out_ch  out  CW  output channel of data_out.
- busy  out  1  layer in progress.
- done  out  1  one-cycle pulse after the final pixel.
- err  out  1  sticky drain-timeout flag.

Behaviour:
- Reset:
  - global_rst, synchronous and active-high, forces IDLE.
  - All outputs go to 0, including err; counters go to 0.
  - Accumulator RAM contents are undefined after reset and are not cleared.
  - Reset mid-layer aborts immediately; no further valid_op is produced.
- Config:
  - cin_cfg/cout_cfg values of 0 are treated as 1; values above CMAX are clamped to CMAX.
  - start is ignored while busy.
- FSM: IDLE -> LOAD -> STREAM -> DRAIN -> NEXT -> (LOAD | FIN) -> IDLE.
  - IDLE: busy=0. On start, latch the config, set co=ci=0, go to LOAD.
  - LOAD, 1 cycle: conv_rst=1, wt_sel updated, pixel and result counters cleared.
  - STREAM, N*N cycles:
    - act_rd_en=1, act_addr advances by 1 per cycle.
    - conv_ce and conv_activation are the 1-cycle-delayed act_rd_en and act_data, so the convolver sees exactly N*N ce cycles of data.
  - DRAIN:
    - conv_ce=1 with conv_activation=0 until the result counter reaches O*O.
    - If DRAIN_MAX cycles elapse first, set err and exit anyway.
  - NEXT: ci++. When ci wraps to 0, co++. Done with all channels -> FIN, else -> LOAD.
  - FIN: done=1 for 1 cycle, then IDLE.
- Result capture, in any state while a pass is active:
  - A result is accepted when valid_conv && !end_conv, up to O*O results per pass; extras are ignored.
  - Result idx = result counter value, 0..O*O-1, row-major.
  - Accumulate: acc[idx] <= (ci==0 ? 0 : acc[idx]) + conv_op.
  - Arithmetic is two's-complement 32-bit and wraps modulo 2^32, with no saturation.
  - If ci is the last input channel: data_out = that sum, valid_op=1 and out_ch=co in the next cycle. The RAM write for the last channel may be skipped.
- Latency: first act_rd_en occurs 2 cycles after start (IDLE->LOAD->STREAM).
- Ordering: valid_op pixels appear strictly in idx order within each co, and co ascends.
- end_conv is used only to qualify valid_conv; it does not terminate a pass.

Decomposition:
- Shared package (cnn_pkg) holds:
  - state enum;
  - derived localparams O and O*O;
  - width helper for CW.
- One sub-module: psum_buffer.
  - O*O × 32 single-port accumulator with a read-modify-write add.
  - Has a first-channel clear input.
  - Registered output.

Test Plan:
- Defaults, cin=1, cout=1, all activations 1, convolver model = 3×3 ones: 64 valid_op, each data_out=9, out_ch=0; done 1 cycle after the last; act_addr covers 0..99.
- cin=3, cout=2, activation channel c = c+1: co0 pixels = 9*(1+2+3) = 54; 128 valid_op total, out_ch 0 ×64 then 1 ×64; wt_sel visits {0,0},{0,1},{0,2},{1,0}…
- cin_cfg=0, cout_cfg=20: behaves as cin=1, cout=16; exactly 1024 valid_op.
- Overflow: conv_op=32'h8000_0000 with cin=2 -> data_out=0 (wrap).
- Convolver model never reaches O*O results (stops at 63): err=1 after DRAIN_MAX cycles, the layer still completes, done pulses, err stays set until global_rst.
- global_rst asserted mid-STREAM of co1, then start: all outputs 0 the cycle after reset; the new layer produces its full, correct output count with no stale pixels.
